// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS main controller with memory ready/wait handshake, bounded-wait bus timeout and illegal-opcode trap.
// Optional feature macro: MC_CTRL_BNE_EN (adds BNE dispatch to BRANCH with an inverted zero test).
module mc_ctrl_hs #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       bus_error,
    output logic       illegal_op,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        FETCH  = 5'd0,  DECODE = 5'd1,  MEMADR = 5'd2,  MEMRD = 5'd3,
        MEMWB  = 5'd4,  MEMWR  = 5'd5,  EXEC   = 5'd6,  RWB   = 5'd7,
        BRANCH = 5'd8,  JUMP   = 5'd9,  JAL    = 5'd10, JR    = 5'd11,
        IEXEC  = 5'd12, IWB    = 5'd13, TRAP   = 5'd31
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mem_state_s;
    logic             wait_expire_s;
    logic             illegal_s;
    logic             take_s;
    logic             bus_error_r;
    logic             illegal_op_r;

    assign mem_state_s   = (state_r == FETCH) | (state_r == MEMRD) | (state_r == MEMWR);
    // mem_ready on the final allowed cycle still wins over the timeout
    assign wait_expire_s = TIMEOUT_EN & mem_state_s & ~mem_ready & (cnt_r == CNT_LAST);

`ifdef MC_CTRL_BNE_EN
    logic ne_r;
    logic set_ne_s;

    // Branch-sense flag: set when BNE is decoded, dropped in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            ne_r <= 1'b0;
        end else if (state_r == FETCH) begin
            ne_r <= 1'b0;
        end else if (set_ne_s) begin
            ne_r <= 1'b1;
        end else begin
            ne_r <= ne_r;
        end
    end

    assign take_s = zero ^ ne_r;
`else
    assign take_s = zero;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait counter and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= {CNT_W{1'b0}};
            bus_error_r  <= 1'b0;
            illegal_op_r <= 1'b0;
        end else begin
            if (next_state_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (mem_state_s && !mem_ready && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            bus_error_r  <= bus_error_r | wait_expire_s;
            illegal_op_r <= illegal_op_r | illegal_s;
        end
    end

    // Next-state and control outputs; everything is held at 0 while rst is high
    always_comb begin
        next_state_s  = state_r;
        illegal_s     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        pc_src        = 2'b00;
        instr_done    = 1'b0;
`ifdef MC_CTRL_BNE_EN
        set_ne_s      = 1'b0;
`endif
        if (rst) begin
            next_state_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        next_state_s = DECODE;
                    end else if (wait_expire_s) begin
                        next_state_s = TRAP;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE:         next_state_s = EXEC;
                        OP_LW, OP_SW:     next_state_s = MEMADR;
                        OP_BEQ:           next_state_s = BRANCH;
                        OP_J:             next_state_s = JUMP;
                        OP_JAL:           next_state_s = JAL;
                        OP_JR:            next_state_s = JR;
                        OP_ADDI, OP_SLTI: next_state_s = IEXEC;
`ifdef MC_CTRL_BNE_EN
                        OP_BNE: begin
                            next_state_s = BRANCH;
                            set_ne_s     = 1'b1;
                        end
`endif
                        default: begin
                            next_state_s = TRAP;
                            illegal_s    = 1'b1;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_SW) begin
                        next_state_s = MEMWR;
                    end else begin
                        next_state_s = MEMRD;
                    end
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        next_state_s = MEMWB;
                    end else if (wait_expire_s) begin
                        next_state_s = TRAP;
                    end else begin
                        next_state_s = MEMRD;
                    end
                end
                MEMWB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b1;
                    instr_done   = 1'b1;
                    next_state_s = FETCH;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done   = 1'b1;
                        next_state_s = FETCH;
                    end else if (wait_expire_s) begin
                        next_state_s = TRAP;
                    end else begin
                        next_state_s = MEMWR;
                    end
                end
                EXEC: begin
                    alu_src_a    = 1'b1;
                    alu_op       = 2'b10;
                    next_state_s = RWB;
                end
                RWB: begin
                    reg_write    = 1'b1;
                    reg_dst      = 2'b01;
                    instr_done   = 1'b1;
                    next_state_s = FETCH;
                end
                IEXEC: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                    alu_op       = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
                    next_state_s = IWB;
                end
                IWB: begin
                    reg_write    = 1'b1;
                    instr_done   = 1'b1;
                    next_state_s = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b10;
                    instr_done    = 1'b1;
                    next_state_s  = FETCH;
                end
                JUMP: begin
                    pc_write     = 1'b1;
                    pc_src       = 2'b01;
                    instr_done   = 1'b1;
                    next_state_s = FETCH;
                end
                JAL: begin
                    reg_write    = 1'b1;
                    reg_dst      = 2'b10;
                    pc_write     = 1'b1;
                    pc_src       = 2'b01;
                    instr_done   = 1'b1;
                    next_state_s = FETCH;
                end
                JR: begin
                    pc_write     = 1'b1;
                    pc_src       = 2'b11;
                    instr_done   = 1'b1;
                    next_state_s = FETCH;
                end
                TRAP:    next_state_s = TRAP;
                default: next_state_s = TRAP;
            endcase
        end
    end

    assign pc_en      = pc_write | (pc_write_cond & take_s);
    assign state      = rst ? 5'd0 : state_r;
    assign bus_error  = rst ? 1'b0 : bus_error_r;
    assign illegal_op = rst ? 1'b0 : illegal_op_r;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed self-checking bench for mc_ctrl_hs: default instance (TIMEOUT=15) plus a TIMEOUT=4 instance on shared inputs.
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic pc_en, pc_write, pc_write_cond, iord, ir_write, alu_src_a;
    logic mem_read, mem_write, mem_to_reg, reg_write, instr_done, bus_error, illegal_op;
    logic [1:0] alu_src_b, alu_op, reg_dst, pc_src;
    logic [4:0] state;

    logic t_pc_en, t_pc_write, t_pc_write_cond, t_iord, t_ir_write, t_alu_src_a;
    logic t_mem_read, t_mem_write, t_mem_to_reg, t_reg_write, t_instr_done, t_bus_error, t_illegal_op;
    logic [1:0] t_alu_src_b, t_alu_op, t_reg_dst, t_pc_src;
    logic [4:0] t_state;

    logic [17:0] ctrl, t_ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, ir_write, alu_src_a, alu_src_b, alu_op,
                   mem_read, mem_write, mem_to_reg, reg_write, reg_dst, pc_src, instr_done};
    assign t_ctrl = {t_pc_write, t_pc_write_cond, t_iord, t_ir_write, t_alu_src_a, t_alu_src_b, t_alu_op,
                     t_mem_read, t_mem_write, t_mem_to_reg, t_reg_write, t_reg_dst, t_pc_src, t_instr_done};

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    mc_ctrl_hs dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .reg_dst(reg_dst), .pc_src(pc_src), .instr_done(instr_done), .bus_error(bus_error),
        .illegal_op(illegal_op), .state(state)
    );

    mc_ctrl_hs #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(t_pc_en), .pc_write(t_pc_write), .pc_write_cond(t_pc_write_cond), .iord(t_iord),
        .ir_write(t_ir_write), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .alu_op(t_alu_op),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .mem_to_reg(t_mem_to_reg), .reg_write(t_reg_write),
        .reg_dst(t_reg_dst), .pc_src(t_pc_src), .instr_done(t_instr_done), .bus_error(t_bus_error),
        .illegal_op(t_illegal_op), .state(t_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0; zero = 1'b0;
        tick();
        vec++;
        if ({state, ctrl, pc_en, bus_error, illegal_op} !== 26'd0) begin
            err++;
            $display("FAIL reset_outputs: state=%0d ctrl=%b pc_en=%b, want all 0", state, ctrl, pc_en);
        end
        rst = 1'b0;
        #1;
        vec++;
        if (state !== 5'd0 || ctrl !== 18'b1_0_0_1_0_01_00_1_0_0_0_00_00_0 || pc_en !== 1'b1) begin
            err++;
            $display("FAIL reset_fetch: state=%0d ctrl=%b pc_en=%b, want 0 %b 1",
                     state, ctrl, pc_en, 18'b1_0_0_1_0_01_00_1_0_0_0_00_00_0);
        end
        vec++;
        if ({bus_error, illegal_op} !== 2'b00) begin
            err++;
            $display("FAIL reset_flags: got %b want 00", {bus_error, illegal_op});
        end
    endtask

    task automatic test_rtype_lw();
        logic [4:0] exp_st [10];
        logic       exp_dn [10];
        exp_st = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
        exp_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_rst();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            opcode = (i < 4) ? 6'b000000 : 6'b100011;
            #1;
            vec++;
            if (state !== exp_st[i] || instr_done !== exp_dn[i]) begin
                err++;
                $display("FAIL rtype_lw[%0d]: state=%0d done=%b, want %0d %b",
                         i, state, instr_done, exp_st[i], exp_dn[i]);
            end
            if (i == 3) begin
                vec++;
                if (reg_dst !== 2'b01 || reg_write !== 1'b1) begin
                    err++;
                    $display("FAIL rwb_regdst: reg_dst=%b reg_write=%b, want 01 1", reg_dst, reg_write);
                end
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        apply_rst();
        opcode = 6'b100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3) ? 1'b0 : 1'b1;
            #1;
            vec++;
            if (state !== 5'd3 || mem_read !== 1'b1 || iord !== 1'b1) begin
                err++;
                $display("FAIL memrd_hold[%0d]: state=%0d mem_read=%b iord=%b, want 3 1 1", i, state, mem_read, iord);
            end
            tick();
        end
        vec++;
        if (state !== 5'd4 || instr_done !== 1'b1 || bus_error !== 1'b0) begin
            err++;
            $display("FAIL memrd_release: state=%0d done=%b bus_error=%b, want 4 1 0", state, instr_done, bus_error);
        end
    endtask

    task automatic test_sw_wait();
        apply_rst();
        opcode = 6'b101011; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        vec++;
        if (state !== 5'd5 || mem_write !== 1'b1 || instr_done !== 1'b0) begin
            err++;
            $display("FAIL memwr_wait: state=%0d mem_write=%b done=%b, want 5 1 0", state, mem_write, instr_done);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        vec++;
        if (state !== 5'd5 || mem_write !== 1'b1 || instr_done !== 1'b1) begin
            err++;
            $display("FAIL memwr_ready: state=%0d mem_write=%b done=%b, want 5 1 1", state, mem_write, instr_done);
        end
        tick();
        vec++;
        if (state !== 5'd0) begin
            err++;
            $display("FAIL memwr_exit: state=%0d want 0", state);
        end
    endtask

    task automatic test_timeout();
        apply_rst();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vec++;
            if (t_state !== 5'd0) begin
                err++;
                $display("FAIL to_wait[%0d]: state=%0d want 0", i, t_state);
            end
            tick();
        end
        vec++;
        if (t_state !== 5'd31 || t_bus_error !== 1'b1 || t_ctrl !== 18'd0 || t_pc_en !== 1'b0) begin
            err++;
            $display("FAIL to_trap: state=%0d bus_error=%b ctrl=%b, want 31 1 0", t_state, t_bus_error, t_ctrl);
        end
        vec++;
        if (state !== 5'd0 || bus_error !== 1'b0 || mem_read !== 1'b1 || ir_write !== 1'b0 || pc_en !== 1'b0) begin
            err++;
            $display("FAIL to15_still_waiting: state=%0d bus_error=%b mem_read=%b ir_write=%b pc_en=%b, want 0 0 1 0 0",
                     state, bus_error, mem_read, ir_write, pc_en);
        end
        mem_ready = 1'b1;
        tick(); tick();
        vec++;
        if (t_state !== 5'd31 || t_bus_error !== 1'b1) begin
            err++;
            $display("FAIL to_sticky: state=%0d bus_error=%b, want 31 1", t_state, t_bus_error);
        end
        apply_rst();
        vec++;
        if (t_state !== 5'd0 || t_bus_error !== 1'b0) begin
            err++;
            $display("FAIL to_reset: state=%0d bus_error=%b, want 0 0", t_state, t_bus_error);
        end
        mem_ready = 1'b0;
        tick(); tick(); tick();
        mem_ready = 1'b1;
        tick();
        vec++;
        if (t_state !== 5'd1 || t_bus_error !== 1'b0) begin
            err++;
            $display("FAIL to_ready_wins: state=%0d bus_error=%b, want 1 0", t_state, t_bus_error);
        end
    endtask

    task automatic test_branch();
        apply_rst();
        opcode = 6'b000100; mem_ready = 1'b1;
        tick(); tick();
        zero = 1'b1;
        #1;
        vec++;
        if (state !== 5'd8 || pc_en !== 1'b1) begin
            err++;
            $display("FAIL beq_taken: state=%0d pc_en=%b, want 8 1", state, pc_en);
        end
        zero = 1'b0;
        #1;
        vec++;
        if (pc_en !== 1'b0) begin
            err++;
            $display("FAIL beq_not_taken: pc_en=%b want 0", pc_en);
        end
    endtask

    task automatic test_dispatch();
        logic [5:0]  ops  [9];
        logic [4:0]  st1  [9];
        logic [4:0]  st2  [9];
        logic [17:0] cv   [9];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                6'b000011, 6'b000110, 6'b001001, 6'b001010};
        st1 = '{5'd6, 5'd2, 5'd2, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd12};
        st2 = '{5'd7, 5'd3, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd13, 5'd13};
        cv  = '{18'b0_0_0_0_1_00_10_0_0_0_0_00_00_0,
                18'b0_0_0_0_1_10_00_0_0_0_0_00_00_0,
                18'b0_0_0_0_1_10_00_0_0_0_0_00_00_0,
                18'b0_1_0_0_1_00_01_0_0_0_0_00_10_1,
                18'b1_0_0_0_0_00_00_0_0_0_0_00_01_1,
                18'b1_0_0_0_0_00_00_0_0_0_1_10_01_1,
                18'b1_0_0_0_0_00_00_0_0_0_0_00_11_1,
                18'b0_0_0_0_1_10_00_0_0_0_0_00_00_0,
                18'b0_0_0_0_1_10_11_0_0_0_0_00_00_0};
        for (int k = 0; k < 9; k++) begin
            apply_rst();
            opcode = ops[k]; mem_ready = 1'b1; zero = 1'b0;
            tick();
            vec++;
            if (state !== 5'd1 || ctrl !== 18'b0_0_0_0_0_11_00_0_0_0_0_00_00_0) begin
                err++;
                $display("FAIL decode op=%b: state=%0d ctrl=%b, want 1 %b",
                         ops[k], state, ctrl, 18'b0_0_0_0_0_11_00_0_0_0_0_00_00_0);
            end
            tick();
            vec++;
            if (state !== st1[k] || ctrl !== cv[k]) begin
                err++;
                $display("FAIL dispatch op=%b: state=%0d ctrl=%b, want %0d %b", ops[k], state, ctrl, st1[k], cv[k]);
            end
            tick();
            vec++;
            if (state !== st2[k]) begin
                err++;
                $display("FAIL follow op=%b: state=%0d want %0d", ops[k], state, st2[k]);
            end
        end
    endtask

    task automatic test_illegal();
        apply_rst();
        opcode = 6'b111111; mem_ready = 1'b1;
        tick(); tick();
        vec++;
        if (state !== 5'd31 || illegal_op !== 1'b1 || ctrl !== 18'd0 || pc_en !== 1'b0) begin
            err++;
            $display("FAIL illegal_trap: state=%0d illegal_op=%b ctrl=%b, want 31 1 0", state, illegal_op, ctrl);
        end
        tick();
        vec++;
        if (state !== 5'd31 || illegal_op !== 1'b1) begin
            err++;
            $display("FAIL illegal_sticky: state=%0d illegal_op=%b, want 31 1", state, illegal_op);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec++;
        if (state !== 5'd0 || illegal_op !== 1'b0 || bus_error !== 1'b0) begin
            err++;
            $display("FAIL trap_reset: state=%0d illegal_op=%b bus_error=%b, want 0 0 0", state, illegal_op, bus_error);
        end
    endtask

    task automatic test_bne();
        apply_rst();
        opcode = 6'b000101; mem_ready = 1'b1; zero = 1'b0;
        tick(); tick();
`ifdef MC_CTRL_BNE_EN
        vec++;
        if (state !== 5'd8 || pc_en !== 1'b1) begin
            err++;
            $display("FAIL bne_taken: state=%0d pc_en=%b, want 8 1", state, pc_en);
        end
        zero = 1'b1;
        #1;
        vec++;
        if (pc_en !== 1'b0) begin
            err++;
            $display("FAIL bne_not_taken: pc_en=%b want 0", pc_en);
        end
        tick();
        opcode = 6'b000100;
        tick(); tick();
        vec++;
        if (state !== 5'd8 || pc_en !== 1'b1) begin
            err++;
            $display("FAIL beq_after_bne: state=%0d pc_en=%b, want 8 1", state, pc_en);
        end
`else
        vec++;
        if (state !== 5'd31 || illegal_op !== 1'b1) begin
            err++;
            $display("FAIL bne_illegal: state=%0d illegal_op=%b, want 31 1", state, illegal_op);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype_lw();
        test_mem_wait();
        test_sw_wait();
        test_timeout();
        test_branch();
        test_dispatch();
        test_illegal();
        test_bne();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
